cic_sample_buf: RTL and testbench

- Downstream stage of the CIC decimator in the PDM microphone path.
- Captures each 32-bit CIC output word on its one-cycle ready strobe, scales it by a programmable right shift, and narrows it to OUT_W bits.
- Buffers the narrowed samples in a small synchronous FIFO.
- Streams the samples to the consumer (UART/host framer) over a valid/ready handshake, with a level count and a sticky overflow flag.

---
 rtl/cic_sample_buf.sv | 128 ++++++++++++
 tb/tb_cic_sample_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_sample_buf.sv
// CIC output capture: shift-scale each strobed 32-bit word, narrow to OUT_W, and queue it in a FIFO
// drained over valid/ready. Optional saturation when narrowing: define CIC_SAMPLE_BUF_SAT_EN.
module cic_sample_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    input  logic [4:0]               shift,
    input  logic                     flush,
    input  logic                     ovf_clr,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic [OUT_W-1:0] stage_q, stage_d;
    logic             stage_vld_q, stage_vld_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      scaled;
    logic             full, empty, pop, wr_en, drop;

    // Stage 1: logical right shift, then narrow (truncate or saturate)
    always_comb begin
        scaled = in_data >> shift;
`ifdef CIC_SAMPLE_BUF_SAT_EN
        if ((scaled >> OUT_W) != 32'd0) begin
            stage_d = '1;
        end else begin
            stage_d = OUT_W'(scaled);
        end
`else
        stage_d = OUT_W'(scaled);
`endif
    end

    // Extra pointer MSB distinguishes full from empty when indices match
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        pop   = !empty && out_ready;
        wr_en = stage_vld_q && (!full || pop) && !flush;
        drop  = stage_vld_q && full && !pop && !flush;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        stage_vld_d = in_valid;
        ovf_d       = ovf_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            stage_vld_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
        end

        // A drop in the same cycle as a clear keeps the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            stage_vld_q <= stage_vld_d;
            ovf_q       <= ovf_d;
            if (in_valid) begin
                stage_q <= stage_d;
            end
        end
    end

    // Storage is reset so the head word reads 0 straight out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= stage_q;
        end
    end

    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cic_sample_buf.sv
// Bench for cic_sample_buf: queue-based reference model checked every cycle plus directed literal checks.
module tb_cic_sample_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned OUT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic [4:0]        shift = '0;
    logic              flush = 1'b0;
    logic              ovf_clr = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [4:0]        level;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cic_sample_buf #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .shift     (shift),
        .flush     (flush),
        .ovf_clr   (ovf_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
    );

    // Reference model: a queue of samples plus one pending scaled sample
    logic [15:0] mq[$];
    logic        m_stage_v = 1'b0;
    logic [15:0] m_stage_n = '0;
    logic        m_ovf = 1'b0;

    function automatic logic [15:0] scale(input logic [31:0] d, input logic [4:0] sh);
        logic [31:0] s;
        s = d >> sh;
`ifdef CIC_SAMPLE_BUF_SAT_EN
        if (s > 32'h0000_FFFF) return 16'hFFFF;
`endif
        return s[15:0];
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int   sz;
        logic m_pop, m_drop;
        if (!rst) begin
            mq.delete();
            m_stage_v = 1'b0;
            m_ovf     = 1'b0;
        end else begin
            sz     = mq.size();
            m_pop  = (sz > 0) && out_ready;
            m_drop = 1'b0;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_stage_v) begin
                    if (sz < int'(DEPTH) || m_pop) mq.push_back(m_stage_n);
                    else m_drop = 1'b1;
                end
            end
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_stage_v = in_valid && !flush;
            if (in_valid) m_stage_n = scale(in_data, shift);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("m_out_data", 32'(out_data), 32'(mq[0]));
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] sh);
        in_valid = 1'b1;
        in_data  = d;
        shift    = sh;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b1;
        step();
        step();

        // Two-cycle latency and scaling
        push(32'h0000_1234, 5'd4);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h0123);
        chk("lat_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_level", 32'(level), 32'd0);
        chk("pop_valid", 32'(out_valid), 32'd0);

        // Fill past full, drain, clear overflow
        for (int i = 1; i <= 17; i++) push(32'(i), 5'd0);
        step();
        step();
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Write and pop together while full
        for (int i = 1; i <= 16; i++) push(32'h100 + 32'(i), 5'd0);
        step();
        chk("full_level", 32'(level), 32'd16);
        push(32'h55, 5'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("wp_level", 32'(level), 32'd16);
        chk("wp_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk("wp_drain", 32'(out_data), 32'h100 + 32'(i));
            step();
        end
        chk("wp_last", 32'(out_data), 32'h55);
        step();
        out_ready = 1'b0;
        chk("wp_empty", 32'(level), 32'd0);

        // Maximum legal shift
        push(32'h8000_0000, 5'd31);
        step();
        chk("shift31", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Narrowing above 16 bits
        push(32'h0003_0000, 5'd0);
        step();
`ifdef CIC_SAMPLE_BUF_SAT_EN
        chk("narrow", 32'(out_data), 32'h0000_FFFF);
`else
        chk("narrow", 32'(out_data), 32'h0000_0000);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush keeps overflow
        for (int i = 1; i <= 17; i++) push(32'h300 + 32'(i), 5'd0);
        step();
        step();
        chk("pre_flush_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        repeat (11) step();
        out_ready = 1'b0;
        chk("pre_flush_level", 32'(level), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset between clock edges
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h400 + 32'(i);
            step();
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
